baud_rate_generator: RTL and testbench



---
 rtl/baud_rate_generator.sv | 68 ++++++
 tb/tb_baud_rate_generator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/baud_rate_generator.sv
// Programmable baud clock divider: produces a 50%-duty square wave at one of
// four rates, each defined by a half-period count of clk cycles.
module baud_rate_generator #(
  parameter int CNT_W  = 16,
  parameter int HALF_0 = 20833,
  parameter int HALF_1 = 10417,
  parameter int HALF_2 = 5208,
  parameter int HALF_3 = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  output logic       clock_out
);

  localparam logic [CNT_W-1:0] LIMIT_0 = CNT_W'(HALF_0 - 1);
  localparam logic [CNT_W-1:0] LIMIT_1 = CNT_W'(HALF_1 - 1);
  localparam logic [CNT_W-1:0] LIMIT_2 = CNT_W'(HALF_2 - 1);
  localparam logic [CNT_W-1:0] LIMIT_3 = CNT_W'(HALF_3 - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic [CNT_W-1:0] limit;
  logic [1:0]       sel_q;
  logic             clock_next;

  // The divisor follows the registered select so a select change is seen
  // as a one-cycle event rather than a mid-count limit swap.
  always_comb begin
    case (sel_q)
      2'b00:   limit = LIMIT_0;
      2'b01:   limit = LIMIT_1;
      2'b10:   limit = LIMIT_2;
      default: limit = LIMIT_3;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    counter_next = counter + ONE;
    clock_next   = clock_out;
    if (sel != sel_q) begin
      // New rate restarts a full half-period; the output level is kept so no
      // short pulse can appear on the switch.
      counter_next = '0;
    end else if (counter >= limit) begin
      counter_next = '0;
      clock_next   = ~clock_out;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter   <= '0;
      clock_out <= 1'b0;
      sel_q     <= sel;
    end else begin
      counter   <= counter_next;
      clock_out <= clock_next;
      sel_q     <= sel;
    end
  end

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed self-checking bench: one divider with default half-periods and one
// with tiny half-periods (4,3,2,1) for select stepping and reset corner cases.
module tb_baud_rate_generator;

  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] sel_a, sel_b;
  logic       out_a, out_b;

  int checks = 0;
  int errors = 0;

  localparam int HALF_A = 10417;
  int half_b[4] = '{4, 3, 2, 1};

  baud_rate_generator dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .sel       (sel_a),
    .clock_out (out_a)
  );

  baud_rate_generator #(
    .HALF_0 (4),
    .HALF_1 (3),
    .HALF_2 (2),
    .HALF_3 (1)
  ) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .sel       (sel_b),
    .clock_out (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts rising clk edges until the selected output changes level; sampling
  // is done on the falling edge. Returns -1 if the budget runs out.
  task automatic wait_toggle(input bit which, input int budget, output int n);
    logic start;
    logic now;
    start = which ? out_b : out_a;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      now = which ? out_b : out_a;
      if (now !== start) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int   n, hi, lo;
    logic level;
    logic exp_lvl;

    rst_a = 1'b1;
    rst_b = 1'b1;
    sel_a = 2'b01;
    sel_b = 2'b00;

    // Reset held for 5 edges on the default-rate divider.
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hold_low", out_a, 1'b0);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;

    // First 100 ns out of reset: low and never X.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_low", out_a, 1'b0);
    end

    wait_toggle(1'b0, HALF_A + 10, n);
    check("first_rise", n, HALF_A - 10);
    check("first_rise_lvl", out_a, 1'b1);

    for (int p = 0; p < 3; p++) begin
      wait_toggle(1'b0, HALF_A + 10, hi);
      check("high_phase", hi, HALF_A);
      wait_toggle(1'b0, HALF_A + 10, lo);
      check("low_phase", lo, HALF_A);
      check("period", hi + lo, 2 * HALF_A);
    end

    // Small divider: fresh reset at sel=00, then step through every select.
    @(negedge clk);
    rst_b = 1'b0;
    sel_b = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("b_rst_low", out_b, 1'b0);
    rst_b = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        wait_toggle(1'b1, 20, n);
        check("b_first_rise", n, half_b[0]);
      end else begin
        sel_b = 2'(s);
        wait_toggle(1'b1, 20, n);
        check("b_switch_phase", n, half_b[s] + 1);
      end
      for (int k = 0; k < 8; k++) begin
        wait_toggle(1'b1, 20, n);
        check("b_half_period", n, half_b[s]);
      end
    end

    // Mid-period switch: sel=00 with counter at 2, then move to sel=10.
    sel_b = 2'b00;
    wait_toggle(1'b1, 20, n);
    check("b_back_to_00", n, half_b[0] + 1);
    @(negedge clk);
    @(negedge clk);
    level = out_b;
    sel_b = 2'b10;
    @(negedge clk);
    check("sw_hold1", out_b, level);
    @(negedge clk);
    check("sw_hold2", out_b, level);
    @(negedge clk);
    exp_lvl = ~level;
    check("sw_toggle", out_b, exp_lvl);
    wait_toggle(1'b1, 20, n);
    check("sw_next_phase", n, half_b[2]);

    // Reset while the output is high.
    if (out_b !== 1'b1) begin
      wait_toggle(1'b1, 20, n);
    end
    check("pre_rst_high", out_b, 1'b1);
    rst_b = 1'b0;
    @(negedge clk);
    check("mid_rst_low", out_b, 1'b0);
    @(negedge clk);
    check("mid_rst_hold", out_b, 1'b0);
    rst_b = 1'b1;
    wait_toggle(1'b1, 20, n);
    check("post_rst_rise", n, half_b[2]);
    check("post_rst_lvl", out_b, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
